// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - opcode, exec_cmd and field constants shared by decoder and encoder
package instr_encoder_pkg;

  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int EXEC_W  = 5;
  localparam int IMM_W   = 16;
  localparam int INSTR_W = 32;

  localparam int OPC_LSB  = 26;
  localparam int DEST_LSB = 21;
  localparam int SRC1_LSB = 16;
  localparam int SRC2_LSB = 11;
  localparam int IMM_LSB  = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd3,
    OP_AND  = 6'd5,
    OP_OR   = 6'd6,
    OP_NOR  = 6'd7,
    OP_XOR  = 6'd8,
    OP_SLA  = 6'd9,
    OP_SLL  = 6'd10,
    OP_SRA  = 6'd11,
    OP_SRL  = 6'd12,
    OP_ADDI = 6'd32,
    OP_SUBI = 6'd33,
    OP_LD   = 6'd36,
    OP_ST   = 6'd37,
    OP_BEZ  = 6'd40,
    OP_BNE  = 6'd41,
    OP_JMP  = 6'd42
  } opcode_e;

  localparam logic [EXEC_W-1:0] EXEC_ADD  = 5'd0;
  localparam logic [EXEC_W-1:0] EXEC_SUB  = 5'd1;
  localparam logic [EXEC_W-1:0] EXEC_AND  = 5'd2;
  localparam logic [EXEC_W-1:0] EXEC_OR   = 5'd3;
  localparam logic [EXEC_W-1:0] EXEC_NOR  = 5'd4;
  localparam logic [EXEC_W-1:0] EXEC_XOR  = 5'd5;
  localparam logic [EXEC_W-1:0] EXEC_SLA  = 5'd6;
  localparam logic [EXEC_W-1:0] EXEC_SLL  = 5'd7;
  localparam logic [EXEC_W-1:0] EXEC_SRA  = 5'd8;
  localparam logic [EXEC_W-1:0] EXEC_SRL  = 5'd9;
  localparam logic [EXEC_W-1:0] EXEC_BEZ  = 5'd14;
  localparam logic [EXEC_W-1:0] EXEC_BNE  = 5'd15;
  localparam logic [EXEC_W-1:0] EXEC_PASS = 5'd16;

  // Control flag vector order: {is_imm, MEM_R_EN, MEM_W_EN, is_br, br_type, is_jmp}
  localparam logic [5:0] CTRL_NONE = 6'b000000;
  localparam logic [5:0] CTRL_IMM  = 6'b100000;
  localparam logic [5:0] CTRL_LD   = 6'b110000;
  localparam logic [5:0] CTRL_ST   = 6'b101000;
  localparam logic [5:0] CTRL_BEZ  = 6'b100110;
  localparam logic [5:0] CTRL_BNE  = 6'b100100;
  localparam logic [5:0] CTRL_JMP  = 6'b100001;

  function automatic logic is_i_format(input opcode_e op);
    return op[5];
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - command bundle in, instruction word out
interface instr_encoder_if;
  import instr_encoder_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [EXEC_W-1:0]   exec_cmd;
  logic                is_imm;
  logic                MEM_R_EN;
  logic                MEM_W_EN;
  logic                is_br;
  logic                br_type;
  logic                is_jmp;
  logic [REG_W-1:0]    dest;
  logic [REG_W-1:0]    src1;
  logic [REG_W-1:0]    src2;
  logic [IMM_W-1:0]    imm;
  logic                out_valid;
  logic                out_ready;
  logic [INSTR_W-1:0]  instr;

  modport master (
    output in_valid, exec_cmd, is_imm, MEM_R_EN, MEM_W_EN, is_br, br_type, is_jmp,
           dest, src1, src2, imm, out_ready,
    input  in_ready, out_valid, instr
  );

  modport slave (
    input  in_valid, exec_cmd, is_imm, MEM_R_EN, MEM_W_EN, is_br, br_type, is_jmp,
           dest, src1, src2, imm, out_ready,
    output in_ready, out_valid, instr
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; read data is zero while empty
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  // A read never frees space for a same-cycle write: full blocks the write outright.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes decoded command bundles into 32-bit instruction words
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  instr_encoder_if.slave   bus,
  output logic             err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] rej_cnt
);
  logic [5:0]         ctrl;
  opcode_e            op;
  logic               enc_ok;
  logic               is_nop;
  logic [INSTR_W-1:0] word;
  logic               full;
  logic               empty;
  logic               accept;
  logic               push;
  logic               reject;

  assign ctrl = {bus.is_imm, bus.MEM_R_EN, bus.MEM_W_EN, bus.is_br, bus.br_type, bus.is_jmp};

  always_comb begin
    op     = OP_NOP;
    enc_ok = 1'b1;
    case (bus.exec_cmd)
      EXEC_ADD: op = (ctrl == CTRL_IMM) ? OP_ADDI : OP_ADD;
      EXEC_SUB: op = (ctrl == CTRL_IMM) ? OP_SUBI : OP_SUB;
      EXEC_AND: op = OP_AND;
      EXEC_OR:  op = OP_OR;
      EXEC_NOR: op = OP_NOR;
      EXEC_XOR: op = OP_XOR;
      EXEC_SLA: op = OP_SLA;
      EXEC_SLL: op = OP_SLL;
      EXEC_SRA: op = OP_SRA;
      EXEC_SRL: op = OP_SRL;
      EXEC_BEZ: begin
        op     = OP_BEZ;
        enc_ok = (ctrl == CTRL_BEZ);
      end
      EXEC_BNE: begin
        op     = OP_BNE;
        enc_ok = (ctrl == CTRL_BNE);
      end
      EXEC_PASS: begin
        if (ctrl == CTRL_LD)       op = OP_LD;
        else if (ctrl == CTRL_ST)  op = OP_ST;
        else if (ctrl == CTRL_JMP) op = OP_JMP;
        else                       enc_ok = 1'b0;
      end
      default: enc_ok = 1'b0;
    endcase
    // R-format rows and the ADDI/SUBI rows admit only their exact flag patterns
    if (bus.exec_cmd <= EXEC_SRL) begin
      if (ctrl != CTRL_NONE && !((bus.exec_cmd <= EXEC_SUB) && ctrl == CTRL_IMM)) enc_ok = 1'b0;
    end
  end

  assign is_nop = (bus.exec_cmd == EXEC_ADD) && (ctrl == CTRL_NONE) &&
                  (bus.dest == '0) && (bus.src1 == '0) && (bus.src2 == '0);

  always_comb begin
    word = '0;
    if (!is_nop) begin
      word[OPC_LSB +: OPC_W]   = op;
      word[SRC1_LSB +: REG_W]  = bus.src1;
      if (is_i_format(op)) begin
        // Stores and BNE carry their second source in the destination slot
        word[DEST_LSB +: REG_W] = (op == OP_ST || op == OP_BNE) ? bus.src2 : bus.dest;
        word[IMM_LSB +: IMM_W]  = bus.imm;
      end else begin
        word[DEST_LSB +: REG_W] = bus.dest;
        word[SRC2_LSB +: REG_W] = bus.src2;
      end
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && enc_ok;
  assign reject        = accept && !enc_ok;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (word),
    .full    (full),
    .rd_en   (bus.out_ready),
    .rd_data (bus.instr),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      enc_cnt <= '0;
      rej_cnt <= '0;
    end else begin
      if (reject) err <= 1'b1;
      if (push && enc_cnt != '1)   enc_cnt <= enc_cnt + CNT_W'(1);
      if (reject && rej_cnt != '1) rej_cnt <= rej_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        err;
  logic [15:0] enc_cnt;
  logic [15:0] rej_cnt;
  int          n_checks = 0;
  int          n_errs   = 0;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err     (err),
    .enc_cnt (enc_cnt),
    .rej_cnt (rej_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ex;
    logic [5:0]  fl;
    logic [4:0]  d;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] ex, input logic [5:0] fl, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [15:0] imm);
    bus.exec_cmd = ex;
    {bus.is_imm, bus.MEM_R_EN, bus.MEM_W_EN, bus.is_br, bus.br_type, bus.is_jmp} = fl;
    bus.dest = d;
    bus.src1 = s1;
    bus.src2 = s2;
    bus.imm  = imm;
  endtask

  // Presents one bundle for exactly one rising edge; returns on the following falling edge.
  task automatic send(input logic [4:0] ex, input logic [5:0] fl, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [15:0] imm);
    drive(ex, fl, d, s1, s2, imm);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5'd16, 6'b110000, 5'd4,  5'd5,  5'd0,  16'h0010, 32'h90850010};
    vecs[1] = '{5'd16, 6'b101000, 5'd0,  5'd2,  5'd7,  16'h0004, 32'h94E20004};
    vecs[2] = '{5'd1,  6'b100000, 5'd1,  5'd2,  5'd0,  16'hFFFF, 32'h8422FFFF};
    vecs[3] = '{5'd14, 6'b100110, 5'd3,  5'd4,  5'd0,  16'h0008, 32'hA0640008};
    vecs[4] = '{5'd15, 6'b100100, 5'd9,  5'd5,  5'd6,  16'h0010, 32'hA4C50010};
    vecs[5] = '{5'd16, 6'b100001, 5'd0,  5'd0,  5'd0,  16'h1234, 32'hA8001234};
    vecs[6] = '{5'd9,  6'b000000, 5'd31, 5'd31, 5'd31, 16'h0000, 32'h33FFF800};
    vecs[7] = '{5'd0,  6'b000000, 5'd0,  5'd0,  5'd0,  16'h0000, 32'h00000000};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(5'd0, 6'b0, 5'd0, 5'd0, 5'd0, 16'h0);
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("rst_instr", bus.instr, 32'd0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    check_eq("rst_enc_cnt", {16'b0, enc_cnt}, 32'd0);
    check_eq("rst_rej_cnt", {16'b0, rej_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);

    bus.out_ready = 1'b1;
    send(5'd0, 6'b000000, 5'd3, 5'd1, 5'd2, 16'h0);
    check_eq("add_valid", {31'b0, bus.out_valid}, 32'd1);
    check_eq("add_instr", bus.instr, 32'h04611000);
    check_eq("add_enc_cnt", {16'b0, enc_cnt}, 32'd1);
    @(negedge clk);
    check_eq("add_drained", {31'b0, bus.out_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].ex, vecs[i].fl, vecs[i].d, vecs[i].s1, vecs[i].s2, vecs[i].imm);
      check_eq($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
      check_eq($sformatf("vec%0d_instr", i), bus.instr, vecs[i].exp);
    end
    @(negedge clk);
    check_eq("vec_drained", {31'b0, bus.out_valid}, 32'd0);
    check_eq("vec_enc_cnt", {16'b0, enc_cnt}, 32'd9);
    check_eq("vec_err_clear", {31'b0, err}, 32'd0);

    send(5'd20, 6'b000000, 5'd1, 5'd1, 5'd1, 16'h0);
    check_eq("rej_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("rej_err", {31'b0, err}, 32'd1);
    check_eq("rej_cnt1", {16'b0, rej_cnt}, 32'd1);
    check_eq("rej_enc_cnt", {16'b0, enc_cnt}, 32'd9);
    send(5'd0, 6'b001000, 5'd1, 5'd1, 5'd1, 16'h0);
    check_eq("rej_cnt2", {16'b0, rej_cnt}, 32'd2);
    send(5'd14, 6'b100100, 5'd1, 5'd1, 5'd1, 16'h0);
    check_eq("rej_cnt3", {16'b0, rej_cnt}, 32'd3);
    check_eq("rej_none_out", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check_eq("err_sticky", {31'b0, err}, 32'd1);

    bus.out_ready = 1'b0;
    drive(5'd0, 6'b0, 5'd1, 5'd0, 5'd0, 16'h0);
    bus.in_valid = 1'b1;
    check_eq("bp_ready0", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    drive(5'd0, 6'b0, 5'd2, 5'd0, 5'd0, 16'h0);
    check_eq("bp_ready1", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    drive(5'd0, 6'b0, 5'd3, 5'd0, 5'd0, 16'h0);
    check_eq("bp_full", {31'b0, bus.in_ready}, 32'd0);
    check_eq("bp_head", bus.instr, 32'h04200000);
    @(negedge clk);
    check_eq("bp_still_full", {31'b0, bus.in_ready}, 32'd0);
    check_eq("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
    check_eq("bp_hold_instr", bus.instr, 32'h04200000);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_second", bus.instr, 32'h04400000);
    check_eq("bp_ready_again", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("bp_third", bus.instr, 32'h04600000);
    check_eq("bp_third_valid", {31'b0, bus.out_valid}, 32'd1);
    @(negedge clk);
    check_eq("bp_drained", {31'b0, bus.out_valid}, 32'd0);
    check_eq("bp_enc_cnt", {16'b0, enc_cnt}, 32'd12);

    bus.out_ready = 1'b0;
    send(5'd0, 6'b0, 5'd1, 5'd0, 5'd0, 16'h0);
    send(5'd0, 6'b0, 5'd2, 5'd0, 5'd0, 16'h0);
    check_eq("rq_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rq_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("rq_instr", bus.instr, 32'd0);
    check_eq("rq_enc_cnt", {16'b0, enc_cnt}, 32'd0);
    check_eq("rq_rej_cnt", {16'b0, rej_cnt}, 32'd0);
    check_eq("rq_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("rq_silent%0d", i), {31'b0, bus.out_valid}, 32'd0);
    end
    check_eq("rq_in_ready", {31'b0, bus.in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
